uart_byte_tx: RTL and testbench

Single-byte UART transmitter with a selectable baud rate. A one-cycle send_en pulse captures an 8-bit byte, which is sent as an 8N1 frame: start bit 0, eight data bits LSB first, stop bit 1. The block sits between on-chip logic and the serial TX pin. It reports busy status on uart_state and emits a one-cycle completion pulse on tx_done.

---
 rtl/uart_pkg.sv | 60 ++++++
 rtl/uart_byte_tx_if.sv | 22 ++
 rtl/uart_baud_tick.sv | 24 ++
 rtl/uart_byte_tx.sv | 94 +++++++++
 tb/tb_uart_byte_tx.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared constants and helpers for the byte-wide 8N1 UART transmitter.
package uart_pkg;

  localparam int unsigned DEF_CLK_FREQ = 50_000_000;
  localparam int          DATA_W       = 8;
  localparam int          DIV_W        = 24;
  localparam int          FRAME_BITS   = 10;
  localparam int          BIT_W        = 4;

  localparam int unsigned RATE_9600    = 9600;
  localparam int unsigned RATE_19200   = 19200;
  localparam int unsigned RATE_38400   = 38400;
  localparam int unsigned RATE_57600   = 57600;
  localparam int unsigned RATE_115200  = 115200;

  // Bit-period divisors at the default system clock.
  localparam int unsigned DIV_9600     = DEF_CLK_FREQ / RATE_9600;
  localparam int unsigned DIV_19200    = DEF_CLK_FREQ / RATE_19200;
  localparam int unsigned DIV_38400    = DEF_CLK_FREQ / RATE_38400;
  localparam int unsigned DIV_57600    = DEF_CLK_FREQ / RATE_57600;
  localparam int unsigned DIV_115200   = DEF_CLK_FREQ / RATE_115200;

  typedef enum logic [2:0] {
    BAUD_9600   = 3'd0,
    BAUD_19200  = 3'd1,
    BAUD_38400  = 3'd2,
    BAUD_57600  = 3'd3,
    BAUD_115200 = 3'd4
  } baud_sel_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } tx_state_e;

  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS - 1);

  // Unlisted encodings fall back to 9600 baud.
  function automatic logic [DIV_W-1:0] baud_div(input logic [2:0] sel,
                                                input int unsigned clk_freq);
    case (sel)
      BAUD_19200:  return DIV_W'(clk_freq / RATE_19200);
      BAUD_38400:  return DIV_W'(clk_freq / RATE_38400);
      BAUD_57600:  return DIV_W'(clk_freq / RATE_57600);
      BAUD_115200: return DIV_W'(clk_freq / RATE_115200);
      default:     return DIV_W'(clk_freq / RATE_9600);
    endcase
  endfunction

  // Line level for frame position idx: start, data LSB first, stop.
  function automatic logic frame_bit(input logic [DATA_W-1:0] d,
                                     input logic [BIT_W-1:0]  idx);
    logic [2:0] sel;
    sel = 3'(idx - BIT_W'(1));
    if (idx == '0)            return 1'b0;
    else if (idx >= LAST_BIT) return 1'b1;
    else                      return d[sel];
  endfunction

endpackage

// File: rtl/uart_byte_tx_if.sv
// Request/status bundle between on-chip logic and the UART transmitter.
interface uart_byte_tx_if;
  import uart_pkg::*;

  logic              send_en;
  logic [DATA_W-1:0] databyte;
  logic [2:0]        baud_set;
  logic              uart_tx;
  logic              tx_done;
  logic              uart_state;

  modport master (
    output send_en, databyte, baud_set,
    input  uart_tx, tx_done, uart_state
  );

  modport slave (
    input  send_en, databyte, baud_set,
    output uart_tx, tx_done, uart_state
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: strobes on the last clock of each bit while enabled.
module uart_baud_tick
  import uart_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic             last;

  assign last = (cnt == div - DIV_W'(1));
  assign tick = en & last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt <= '0;
    else if (!en || last) cnt <= '0;
    else                  cnt <= cnt + DIV_W'(1);
  end

endmodule

// File: rtl/uart_byte_tx.sv
// Single-byte 8N1 UART transmitter with selectable baud rate and a registered line.
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = DEF_CLK_FREQ
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  uart_byte_tx_if.slave  bus
);

  tx_state_e         state, state_nxt;
  logic [BIT_W-1:0]  bit_idx, bit_idx_nxt;
  logic [DATA_W-1:0] data_lat;
  logic [DIV_W-1:0]  div_lat;
  logic              latch_en;
  logic              bit_tick;
  logic              tx_q, tx_nxt;
  logic              done_q, done_nxt;
  logic              busy_q, busy_nxt;

  uart_baud_tick u_baud_tick (
    .clk  (sys_clk),
    .rst  (sys_rst),
    .en   (state == ST_SEND),
    .div  (div_lat),
    .tick (bit_tick)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state    <= ST_IDLE;
      bit_idx  <= '0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      data_lat <= '0;
      div_lat  <= '0;
    end else begin
      state   <= state_nxt;
      bit_idx <= bit_idx_nxt;
      tx_q    <= tx_nxt;
      done_q  <= done_nxt;
      busy_q  <= busy_nxt;
      if (latch_en) begin
        data_lat <= bus.databyte;
        div_lat  <= baud_div(bus.baud_set, CLK_FREQ);
      end
    end
  end

  // Outputs are computed one clock ahead so the line and status stay registered.
  always_comb begin
    state_nxt   = state;
    bit_idx_nxt = bit_idx;
    tx_nxt      = 1'b1;
    done_nxt    = 1'b0;
    busy_nxt    = 1'b0;
    latch_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.send_en) begin
          state_nxt   = ST_SEND;
          bit_idx_nxt = '0;
          tx_nxt      = 1'b0;
          busy_nxt    = 1'b1;
          latch_en    = 1'b1;
        end
      end
      ST_SEND: begin
        busy_nxt = 1'b1;
        tx_nxt   = frame_bit(data_lat, bit_idx);
        if (bit_tick) begin
          if (bit_idx == LAST_BIT) begin
            state_nxt   = ST_IDLE;
            bit_idx_nxt = '0;
            tx_nxt      = 1'b1;
            done_nxt    = 1'b1;
            busy_nxt    = 1'b0;
          end else begin
            bit_idx_nxt = bit_idx + BIT_W'(1);
            tx_nxt      = frame_bit(data_lat, bit_idx + BIT_W'(1));
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.uart_tx    = tx_q;
  assign bus.tx_done    = done_q;
  assign bus.uart_state = busy_q;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Scoreboard bench for uart_byte_tx: stimulus queues expected frames, a monitor checks the line.
module tb_uart_byte_tx;

  localparam int unsigned CLK_FREQ = 50_000_000;
  localparam int          CLK_P    = 10;

  typedef struct {
    logic [7:0] b;
    int         div;
    longint     t0;
  } exp_t;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  int   checks  = 0;
  int   errors  = 0;
  int   rates [8] = '{9600, 19200, 38400, 57600, 115200, 9600, 9600, 9600};

  exp_t exp_q[$];
  exp_t cur;
  bit   active    = 1'b0;
  bit   pend_done = 1'b0;
  bit   chk_after = 1'b0;
  int   cyc, bad, badst, k;

  always #5 sys_clk = ~sys_clk;

  uart_byte_tx_if bus ();

  uart_byte_tx #(.CLK_FREQ(CLK_FREQ)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus.slave)
  );

  function automatic int model_div(input logic [2:0] sel);
    return CLK_FREQ / rates[sel];
  endfunction

  function automatic logic model_bit(input logic [7:0] b, input int pos);
    logic [7:0] s;
    if (pos == 0) return 1'b0;
    if (pos >= 9) return 1'b1;
    s = b >> (pos - 1);
    return s[0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, req, $time);
    end
  endtask

  // Monitor: consumes one expected frame per observed start bit.
  always @(negedge sys_clk) begin
    if (sys_rst) begin
      active    = 1'b0;
      pend_done = 1'b0;
      chk_after = 1'b0;
    end else begin
      if (chk_after) begin
        check("done_width", 32'(bus.tx_done), 32'd0);
        chk_after = 1'b0;
      end
      if (pend_done) begin
        check("tx_done", 32'(bus.tx_done), 32'd1);
        check("state_fall", 32'(bus.uart_state), 32'd0);
        check("line_idle", 32'(bus.uart_tx), 32'd1);
        check("frame_status", 32'(badst), 32'd0);
        pend_done = 1'b0;
        chk_after = 1'b1;
      end else if (!active && bus.uart_tx === 1'b0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_start", 32'd1, 32'd0);
        end else begin
          cur = exp_q.pop_front();
          check("start_time", 32'($time), 32'(cur.t0));
          active = 1'b1;
          cyc    = 0;
          bad    = 0;
          badst  = 0;
        end
      end
      if (active) begin
        k = cyc / cur.div;
        if (bus.uart_tx !== model_bit(cur.b, k)) bad++;
        if (bus.uart_state !== 1'b1 || bus.tx_done !== 1'b0) badst++;
        cyc++;
        if (cyc % cur.div == 0) begin
          check($sformatf("bit%0d_byte%02h_div%0d", k, cur.b, cur.div), 32'(bad), 32'd0);
          bad = 0;
        end
        if (cyc == 10 * cur.div) begin
          active    = 1'b0;
          pend_done = 1'b1;
        end
      end
    end
  end

  task automatic send(input logic [7:0] b, input logic [2:0] sel);
    exp_t e;
    @(negedge sys_clk);
    bus.send_en  = 1'b1;
    bus.databyte = b;
    bus.baud_set = sel;
    e.b   = b;
    e.div = model_div(sel);
    e.t0  = longint'($time) + CLK_P;
    exp_q.push_back(e);
    @(negedge sys_clk);
    bus.send_en  = 1'b0;
    bus.databyte = 8'($urandom);
    bus.baud_set = 3'($urandom);
  endtask

  task automatic wait_done(input int max_cyc, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge sys_clk);
      if (bus.tx_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, 32'(seen), 32'd1);
  endtask

  task automatic idle_check(input int n, input string name);
    int nbad;
    nbad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      if (bus.uart_tx !== 1'b1 || bus.tx_done !== 1'b0 || bus.uart_state !== 1'b0) nbad++;
    end
    check(name, 32'(nbad), 32'd0);
  endtask

  task automatic reset_now(input string name);
    @(negedge sys_clk);
    #2 sys_rst = 1'b1;
    #1;
    check({name, "_tx"}, 32'(bus.uart_tx), 32'd1);
    check({name, "_state"}, 32'(bus.uart_state), 32'd0);
    check({name, "_done"}, 32'(bus.tx_done), 32'd0);
    repeat (4) @(negedge sys_clk);
    #2 sys_rst = 1'b0;
  endtask

  initial begin
    #1_200_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int nbad;
    bus.send_en  = 1'b0;
    bus.databyte = 8'h00;
    bus.baud_set = 3'd4;

    nbad = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge sys_clk);
      if (bus.uart_tx !== 1'b1 || bus.tx_done !== 1'b0 || bus.uart_state !== 1'b0) nbad++;
    end
    check("reset_hold", 32'(nbad), 32'd0);
    #2 sys_rst = 1'b0;
    idle_check(20, "idle_after_reset");

    send(8'hAA, 3'd4);
    wait_done(4400, "done_aa");

    repeat (5000) @(negedge sys_clk);
    send(8'h55, 3'd4);
    repeat (1000) @(negedge sys_clk);
    bus.send_en  = 1'b1;
    bus.databyte = 8'hFF;
    bus.baud_set = 3'd0;
    @(negedge sys_clk);
    bus.send_en  = 1'b0;
    bus.baud_set = 3'd2;
    repeat (500) @(negedge sys_clk);
    bus.send_en  = 1'b1;
    bus.databyte = 8'($urandom);
    bus.baud_set = 3'd1;
    @(negedge sys_clk);
    bus.send_en  = 1'b0;
    wait_done(4400, "done_55");

    send(8'($urandom), 3'd4);
    wait_done(4400, "done_back_to_back");

    send(8'h01, 3'd0);
    wait_done(52200, "done_9600");

    send(8'($urandom), 3'd7);
    repeat (2 * 5208 + 100) @(negedge sys_clk);
    reset_now("rst_sel7");
    idle_check(50, "idle_after_rst_sel7");

    send(8'($urandom), 3'd4);
    repeat (4 * 434 + 217) @(negedge sys_clk);
    reset_now("rst_bit3");
    idle_check(500, "no_done_after_abort");

    send(8'($urandom), 3'd4);
    wait_done(4400, "done_after_abort");
    idle_check(20, "idle_final");
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
